// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave on clk_100mhz: synchronised SCLK/CS_N/MOSI, MSB-first rx/tx words.
// Latency: rx_valid pulses SYNC_STAGES+1 edges after the 8th SCLK rise is first sampled.
// Backpressure: none on rx; tx accepts one word when tx_ready=1, empty buffer -> zeros.
module spi_slave_rx_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [0:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      shift_rx;
    logic [DATA_W-1:0]      shift_tx;
    logic [DATA_W-1:0]      tx_buf;
    logic                   tx_full;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign tx_ready  = ~tx_full;
    assign miso      = cs_s ? 1'b0 : shift_tx[DATA_W-1];

    // Synchronisers reset to the idle bus state so reset never fakes an edge.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_rx    <= '0;
            shift_tx    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (cs_fall) begin
                state       <= ACTIVE;
                bit_cnt     <= '0;
                busy        <= 1'b1;
                shift_tx    <= tx_full ? tx_buf : '0;
                tx_full     <= 1'b0;
                tx_underrun <= ~tx_full;
            end else if (state == ACTIVE) begin
                if (cs_rise) begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                end else if (sclk_rise) begin
                    shift_rx <= {shift_rx[DATA_W-2:0], mosi_s};
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        rx_data  <= {shift_rx[DATA_W-2:0], mosi_s};
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt != '0) begin
                        shift_tx <= shift_tx << 1;
                    end else begin
                        // Back-to-back word: reload before the next word's first rise.
                        shift_tx <= tx_full ? tx_buf : '0;
                        tx_full  <= 1'b0;
                    end
                end
            end
            // Accept after any load so a word offered to an empty buffer is kept.
            if (tx_valid && tx_ready) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule
